// File: rtl/storage_sync_fifo_pkg.sv
// Shared constants and helpers for the STORAGE FIFO family.
package storage_sync_fifo_pkg;

  localparam int STORAGE_DATA_WIDTH = 8;
  localparam int STORAGE_DEPTH      = 4;

  // Pointer width for a power-of-two depth.
  function automatic int addr_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/storage_sync_fifo_if.sv
// Producer/consumer bus of the STORAGE sync FIFO.
//
// Handshake: a write is taken on a rising clk edge where wr_en=1 and full=0.
// A read is taken on a rising edge where rd_en=1 and empty=0. Its word shows
// up on rd_data one cycle later, qualified by a one-cycle rd_valid pulse.
// Requests made while blocked are dropped, so the requester keeps asserting
// until its flag clears. full/empty/count come from registered state only.
interface storage_sync_fifo_if
  import storage_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = STORAGE_DATA_WIDTH,
  parameter int DEPTH      = STORAGE_DEPTH
) ();

  localparam int ADDR_BIT = addr_bits(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic [ADDR_BIT:0]     count;

  // Producer and consumer side.
  modport master (
    output wr_en, wr_data, rd_en,
    input  full, rd_data, rd_valid, empty, count
  );

  // FIFO side.
  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, rd_data, rd_valid, empty, count
  );

endinterface

// File: rtl/storage_updown_cnt.sv
// Occupancy up/down counter. An inc together with a dec cancels out.
module storage_updown_cnt #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Count moves by one only when exactly one of inc/dec is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end

  // The caller gates inc/dec with full/empty, so these must never fire.
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n)
                                   !(inc && !dec && count == MAX_V));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(dec && !inc && count == '0));
  a_in_range:     assert property (@(posedge clk) disable iff (!rst_n)
                                   count <= MAX_V);

endmodule

// File: rtl/storage_sync_fifo.sv
// Single-clock FIFO with registered read data, for the STORAGE subsystem.
module storage_sync_fifo
  import storage_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = STORAGE_DATA_WIDTH,
  parameter int DEPTH      = STORAGE_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  storage_sync_fifo_if.slave  bus
);

  localparam int ADDR_BIT = addr_bits(DEPTH);
  localparam logic [ADDR_BIT:0] DEPTH_V = (ADDR_BIT+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("storage_sync_fifo: DEPTH must be a power of two, at least 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BIT-1:0]   wr_ptr;
  logic [ADDR_BIT-1:0]   rd_ptr;
  logic [ADDR_BIT:0]     count;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode the registered count, so they lag the moving edge by one.
  assign full   = (count == DEPTH_V);
  assign empty  = (count == '0);
  // A write into an empty FIFO is not bypassed to a same-cycle read.
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & ~empty;

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointers wrap through natural overflow of the ADDR_BIT-wide registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Registered read port: data lands one cycle after the accepting edge, then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem[rd_ptr];
    end
  end

  storage_updown_cnt #(
    .MAX (DEPTH),
    .W   (ADDR_BIT + 1)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_acc),
    .dec   (rd_acc),
    .count (count)
  );

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule
